// File: rtl/fb_sram_arbiter.sv
// Framebuffer SRAM arbiter: shares one async SRAM between video scanout (read-only)
// and the CPU bus (read/write), with round-robin tie-break and fully registered SRAM strobes.
module fb_sram_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 8,
  parameter int WR_PULSE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              sram_cs_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int CNT_W = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD1      = 3'd1;
  localparam logic [2:0] S_RD2      = 3'd2;
  localparam logic [2:0] S_WR_SETUP = 3'd3;
  localparam logic [2:0] S_WR_PULSE = 3'd4;
  localparam logic [2:0] S_WR_HOLD  = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  logic [2:0]        state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              turn_r, turn_s;
  logic              gnt_cpu_r, gnt_cpu_s;
  logic              last_cpu_r, last_cpu_s;
  logic              vid_win_s;
  logic              done_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] dq_out_s, vid_data_s, cpu_rdata_s;
  logic              cs_n_s, oe_n_s, we_n_s, dq_oe_s;

  // Next-state, grant and capture logic
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    turn_s      = turn_r;
    gnt_cpu_s   = gnt_cpu_r;
    last_cpu_s  = last_cpu_r;
    addr_s      = sram_addr;
    dq_out_s    = sram_dq_out;
    vid_data_s  = vid_data;
    cpu_rdata_s = cpu_rdata;
    // Video wins unless the CPU also asks and video was served last.
    vid_win_s   = vid_req & (~cpu_req | last_cpu_r);

    case (state_r)
      S_IDLE: begin
        if (vid_req | cpu_req) begin
          gnt_cpu_s  = ~vid_win_s;
          last_cpu_s = ~vid_win_s;
          if (vid_win_s) begin
            addr_s  = vid_addr;
            state_s = S_RD1;
          end else begin
            addr_s = cpu_addr;
            if (cpu_we) begin
              dq_out_s = cpu_wdata;
              state_s  = S_WR_SETUP;
            end else begin
              state_s = S_RD1;
            end
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RD1: state_s = S_RD2;
      S_RD2: begin
        if (gnt_cpu_r) begin
          cpu_rdata_s = sram_dq_in;
        end else begin
          vid_data_s = sram_dq_in;
        end
        state_s = S_DONE;
      end
      S_WR_SETUP: begin
        cnt_s   = CNT_W'(WR_PULSE - 1);
        state_s = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        if (cnt_r == '0) begin
          state_s = S_WR_HOLD;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      S_WR_HOLD: begin
        // One bus-turnaround cycle after releasing DQ before the CPU is acked.
        turn_s  = 1'b1;
        state_s = S_DONE;
      end
      S_DONE: begin
        if (turn_r) begin
          turn_s = 1'b0;
        end else begin
          state_s = S_IDLE;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Strobe and completion decode from the state being entered
  always_comb begin
    cs_n_s  = 1'b1;
    oe_n_s  = 1'b1;
    we_n_s  = 1'b1;
    dq_oe_s = 1'b0;
    case (state_s)
      S_RD1, S_RD2: begin
        cs_n_s = 1'b0;
        oe_n_s = 1'b0;
      end
      S_WR_SETUP, S_WR_HOLD: begin
        cs_n_s  = 1'b0;
        dq_oe_s = 1'b1;
      end
      S_WR_PULSE: begin
        cs_n_s  = 1'b0;
        we_n_s  = 1'b0;
        dq_oe_s = 1'b1;
      end
      default: begin
        cs_n_s  = 1'b1;
        dq_oe_s = 1'b0;
      end
    endcase
    done_s = (state_s == S_DONE) & ~turn_s;
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      cnt_r       <= '0;
      turn_r      <= 1'b0;
      gnt_cpu_r   <= 1'b0;
      last_cpu_r  <= 1'b1;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_cs_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      vid_data    <= '0;
      cpu_rdata   <= '0;
      vid_valid   <= 1'b0;
      cpu_ack     <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      turn_r      <= turn_s;
      gnt_cpu_r   <= gnt_cpu_s;
      last_cpu_r  <= last_cpu_s;
      sram_addr   <= addr_s;
      sram_dq_out <= dq_out_s;
      sram_dq_oe  <= dq_oe_s;
      sram_cs_n   <= cs_n_s;
      sram_oe_n   <= oe_n_s;
      sram_we_n   <= we_n_s;
      vid_data    <= vid_data_s;
      cpu_rdata   <= cpu_rdata_s;
      vid_valid   <= done_s & ~gnt_cpu_s;
      cpu_ack     <= done_s & gnt_cpu_s;
    end
  end

endmodule
